uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx byte channel between two requesters using packet-granular round-robin.
//  A requester owns the channel from its first accepted byte to its byte flagged last.
//  The block sits between byte producers (message sequencer, rx echo path) and the
//  uart_tx instance inside the uart top. It has a one-byte registered output stage.
// PARAMETERS
//  MAX_BURST     64      forced release after this many bytes without last; 0 = no limit
//  TIMEOUT_CLKS  270000  idle clocks before a stalled owner is released (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  req0_valid     in   1  requester 0 presents a byte
//  req0_data      in   8  requester 0 byte
//  req0_last      in   1  byte is the final byte of requester 0's packet
//  req0_ready     out  1  requester 0 byte accepted when req0_valid&&req0_ready
//  req1_valid/req1_data/req1_last/req1_ready   same as req0_* for requester 1
//  tx_data        out  8  byte to uart_tx (registered)
//  tx_data_valid  out  1  byte valid to uart_tx (registered)
//  tx_data_ready  in   1  uart_tx accepts when tx_data_valid&&tx_data_ready
//  grant          out  2  one-hot owner; 2'b00 = none
//  busy           out  1  state != IDLE
//  timeout_flag   out  1  1-cycle pulse on timeout release
// BEHAVIOUR
//  Reset (async, all outputs): tx_data=8'h00, tx_data_valid=0, grant=2'b00, busy=0, timeout_flag=0.
//   On reset, last_owner=1, so req0 wins the first tie. Burst and timeout counters reset to 0.
//  FSM states: IDLE, OWN, DRAIN.
//   IDLE: grant=00, both ready=0.
//    - Single valid requester: it wins.
//    - Both valid: the requester != last_owner wins.
//    - Next cycle: OWN with grant set. Latency from valid to ready is 1 clk.
//   OWN: reqN_ready = grant[N] && !tx_data_valid (combinational). The other requester's ready=0.
//    - On accept: tx_data<=reqN_data, tx_data_valid<=1, burst_cnt++.
//    - If reqN_last, or burst_cnt reaches MAX_BURST on this accept (MAX_BURST!=0): go to DRAIN.
//   DRAIN: no new accepts. Wait for tx_data_valid&&tx_data_ready.
//    - Then: tx_data_valid<=0, last_owner<=owner, grant<=00, burst_cnt<=0, go to IDLE.
//    - Packets are therefore separated by >=1 IDLE cycle.
//  Output stage, all states:
//   - tx_data_valid stays 1 with tx_data stable until accepted.
//   - On accept in OWN, tx_data_valid<=0 unless a new byte is loaded that cycle.
//   - A new byte cannot be loaded that cycle, because ready requires !tx_data_valid.
//   - Net effect: one byte in flight at most.
//  Owner drops valid mid-packet: grant is held (subject to the timeout feature). The other requester waits.
//  Ready/valid ignored for a non-granted requester; its data need not be stable.
//  burst_cnt is 16 bits and saturates. The MAX_BURST compare uses ==.
//  Reset mid-packet: the byte in flight is discarded and grant is dropped immediately.
//   uart_tx sees tx_data_valid fall asynchronously.
// CONFIGURATION
//  `define UART_ARB_TIMEOUT_EN:
//   - Active in OWN with tx_data_valid=0 and reqN_valid=0 for the owner.
//   - A 32-bit idle counter increments each such cycle and clears on any owner accept.
//   - When it reaches TIMEOUT_CLKS: grant<=00, last_owner<=owner, timeout_flag=1 for one clk, go to IDLE.
//  Undefined:
//   - No counter is built and timeout_flag is tied 0.
//   - A stalled owner holds grant indefinitely; only last or MAX_BURST releases it.
// TESTING
//  uart_tx model: tx_data_ready drops for 8 clks after each accept.
//  1 req0 sends 0x48, then 0x69 with last.
//    -> tx sees 0x48 then 0x69 in order; grant=01 throughout; grant=00 the clk after 0x69 is accepted.
//  2 req0 and req1 both valid in the first cycle after reset (req1: 0x41, 0x42 last).
//    -> req0's full packet first, req1_ready=0 throughout it; then grant=10 and 0x41, 0x42.
//  3 Immediately after test 2, both request again.
//    -> req0 granted (last_owner=1); the next tie goes to req1. Check 4 alternating packets.
//  4 MAX_BURST=4; req0 streams 0x01..0x06 with no last; req1 is pending.
//    -> release after 0x04 accepted; req1 packet sent; then req0 resumes with 0x05.
//  5 Macro on, TIMEOUT_CLKS=16; req0 sends 0x55 (no last), then drops valid.
//    -> after 16 idle clks: timeout_flag pulse, grant=00. Macro off: grant stays 01 for 1000 clks.
//  6 rst_n low while tx_data_valid=1 in OWN.
//    -> tx_data_valid=0, grant=00, busy=0 before the next clk edge; normal operation after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin share of one uart_tx byte channel between two requesters.
// Define UART_ARB_TIMEOUT_EN to build the stalled-owner timeout release.
module uart_tx_arbiter #(
    parameter int MAX_BURST    = 64,
    parameter int TIMEOUT_CLKS = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_flag
);
    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    localparam logic [15:0] MAX_B = 16'(MAX_BURST);

    state_t      state, state_n;
    logic        last_owner, owner, own_valid, own_last, accept, tx_done, pick1, burst_hit, tmo_hit;
    logic [7:0]  own_data;
    logic [15:0] burst_cnt, burst_inc;

    assign owner      = grant[1];
    assign own_valid  = owner ? req1_valid : req0_valid;
    assign own_last   = owner ? req1_last : req0_last;
    assign own_data   = owner ? req1_data : req0_data;
    assign req0_ready = state == OWN && grant[0] && !tx_data_valid;
    assign req1_ready = state == OWN && grant[1] && !tx_data_valid;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign tx_done    = tx_data_valid && tx_data_ready;
    // on a tie the requester that did not own the previous packet wins
    assign pick1      = req1_valid && (!req0_valid || !last_owner);
    assign burst_inc  = burst_cnt + 16'(burst_cnt != 16'hFFFF);
    assign burst_hit  = MAX_BURST != 0 && burst_inc == MAX_B;
    assign busy       = state != IDLE;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        idle_cyc;

    assign idle_cyc = state == OWN && !tx_data_valid && !own_valid;
    assign tmo_hit  = idle_cyc && idle_cnt + 32'd1 == 32'(TIMEOUT_CLKS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            idle_cnt     <= (accept || state != OWN || tmo_hit) ? 32'd0 : idle_cnt + 32'(idle_cyc);
            timeout_flag <= tmo_hit;
        end
    end
`else
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0 && TIMEOUT_CLKS != 0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (req0_valid || req1_valid) ? OWN : IDLE;
            OWN:     state_n = tmo_hit ? IDLE : (accept && (own_last || burst_hit)) ? DRAIN : OWN;
            DRAIN:   state_n = tx_done ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= 2'b00;
            last_owner    <= 1'b1;
            burst_cnt     <= '0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                tx_data       <= own_data;
                tx_data_valid <= 1'b1;
                burst_cnt     <= burst_inc;
            end else if (tx_done) begin
                tx_data_valid <= 1'b0;
            end
            if (state == IDLE && state_n == OWN) begin
                grant <= pick1 ? 2'b10 : 2'b01;
            end else if ((state == DRAIN && tx_done) || tmo_hit) begin
                grant      <= 2'b00;
                last_owner <= owner;
                burst_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of packet arbitration, burst release, stall/timeout and async reset.
// Built with MAX_BURST=4 and TIMEOUT_CLKS=16; stall expectations follow UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready = 1'b1;
    logic [1:0] grant;
    logic       busy, timeout_flag;

    int passed = 0, total = 0, fails = 0, viol = 0, rd = 0, cool = 0;
    bit pend = 0, hs0 = 0, hs1 = 0;
    logic [8:0] q0[$], q1[$];
    logic [9:0] tx_log[$];

    uart_tx_arbiter #(.MAX_BURST(4), .TIMEOUT_CLKS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .grant(grant), .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    // uart_tx model: every accepted byte is logged as {grant, data}, then ready drops for 8 clks
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_data_ready = 1'b1;
            pend = 0;
            cool = 0;
        end else begin
            if (pend) begin
                pend = 0;
                tx_data_ready = 1'b0;
                cool = 8;
            end else if (cool > 0) begin
                cool--;
                if (cool == 0) tx_data_ready = 1'b1;
            end
            if (tx_data_valid && tx_data_ready) begin
                tx_log.push_back({grant, tx_data});
                pend = 1;
            end
        end
    end

    // requester sources: present queue heads, pop after the handshake edge
    always @(negedge clk) begin
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        req0_valid = rst_n && q0.size() > 0;
        req1_valid = rst_n && q1.size() > 0;
        {req0_last, req0_data} = req0_valid ? q0[0] : 9'h0;
        {req1_last, req1_data} = req1_valid ? q1[0] : 9'h0;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if ((req0_ready && grant !== 2'b01) || (req1_ready && grant !== 2'b10)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (tx_log.size() < n && k < 3000) begin
            step(1);
            k++;
        end
        chk("log_wait", 32'(tx_log.size() >= n), 1);
    endtask

    task automatic exp_log(input string tag, input logic [9:0] e);
        chk(tag, (rd < tx_log.size()) ? 32'(tx_log[rd]) : 'x, 32'(e));
        rd++;
    endtask

    initial begin
        int bad = 0, k = 0;
        #3;
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_valid", 32'(tx_data_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo", 32'(timeout_flag), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        // 1: single two-byte packet from req0
        q0.push_back(9'h048);
        q0.push_back(9'h169);
        wait_log(2);
        exp_log("t1_b0", 10'h148);
        exp_log("t1_b1", 10'h169);
        chk("t1_grant_off", 32'(grant), 0);
        // 2: both valid in the first cycle after reset, req0 wins the tie
        rst_n = 1'b0;
        q0.push_back(9'h010);
        q0.push_back(9'h111);
        q1.push_back(9'h041);
        q1.push_back(9'h142);
        step(1);
        rst_n = 1'b1;
        wait_log(6);
        exp_log("t2_b0", 10'h110);
        exp_log("t2_b1", 10'h111);
        exp_log("t2_b2", 10'h241);
        exp_log("t2_b3", 10'h242);
        chk("t2_grant_off", 32'(grant), 0);
        // 3: alternating packets with both always pending
        q0.push_back(9'h020);
        q0.push_back(9'h121);
        q0.push_back(9'h122);
        q1.push_back(9'h130);
        q1.push_back(9'h131);
        wait_log(11);
        exp_log("t3_b0", 10'h120);
        exp_log("t3_b1", 10'h121);
        exp_log("t3_b2", 10'h230);
        exp_log("t3_b3", 10'h122);
        exp_log("t3_b4", 10'h231);
        // 4: forced release after four bytes without last
        for (int i = 1; i <= 6; i++) q0.push_back(9'(i));
        q1.push_back(9'h177);
        wait_log(18);
        exp_log("t4_b1", 10'h101);
        exp_log("t4_b2", 10'h102);
        exp_log("t4_b3", 10'h103);
        exp_log("t4_b4", 10'h104);
        exp_log("t4_req1", 10'h277);
        exp_log("t4_b5", 10'h105);
        exp_log("t4_b6", 10'h106);
        // 5: req0 sends one more byte then stalls
        q0.push_back(9'h055);
        wait_log(19);
        exp_log("t5_b", 10'h155);
`ifdef UART_ARB_TIMEOUT_EN
        step(15);
        chk("t5_pre_grant", 32'(grant), 32'h1);
        chk("t5_pre_tmo", 32'(timeout_flag), 0);
        step(1);
        chk("t5_tmo_pulse", 32'(timeout_flag), 1);
        chk("t5_tmo_grant", 32'(grant), 0);
        chk("t5_tmo_busy", 32'(busy), 0);
        step(1);
        chk("t5_tmo_end", 32'(timeout_flag), 0);
`else
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (grant !== 2'b01 || timeout_flag !== 1'b0) bad++;
        end
        chk("t5_stall_hold", 32'(bad), 0);
        chk("t5_busy", 32'(busy), 1);
`endif
        // 6: async reset while a byte is in flight
        q0.push_back(9'h099);
        while (tx_data_valid !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        chk("t6_loaded", 32'(tx_data_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(tx_data_valid), 0);
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        q0.delete();
        step(1);
        rst_n = 1'b1;
        q1.push_back(9'h1A5);
        wait_log(20);
        exp_log("t6_after", 10'h2A5);
        chk("t6_grant_off", 32'(grant), 0);
        chk("ready_excl", 32'(viol), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
